fwd_hazard_ctrl: RTL and testbench

- Generates the select lines for the EX-stage operand mux3 instances: 00 = register file, 01 = WB result, 10 = MEM result.
- Also produces load-use stall and branch flush control for the 5-stage pipeline.
- Keeps its own shadow pipeline (EX/MEM/WB) of register-use fields, advanced in lockstep with the datapath pipeline registers.
- Sits beside the decode stage; consumes decoded fields and drives the selects and the PC/IF-ID hold and flush controls.

---
 rtl/fwd_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects, load-use stall and branch flush control
module fwd_hazard_ctrl #(
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            branch_taken,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic            stall,
   output logic            flush_id,
   output logic            ex_bubble,
   output logic [CNTW-1:0] stall_cnt
);

   logic            ex_valid, ex_regwrite, ex_memread;
   logic [REGW-1:0] ex_rd, ex_rs1, ex_rs2;
   logic            mem_valid, mem_regwrite, mem_memread;
   logic [REGW-1:0] mem_rd;
   logic            wb_valid, wb_regwrite, wb_memread;
   logic [REGW-1:0] wb_rd;

   logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic ex_load_hit;

   // A load still in MEM has no data yet, so it is never a forwarding source.
   assign mem_hit_a = mem_valid & mem_regwrite & ~mem_memread & (mem_rd == ex_rs1) & (ex_rs1 != '0);
   assign mem_hit_b = mem_valid & mem_regwrite & ~mem_memread & (mem_rd == ex_rs2) & (ex_rs2 != '0);
   assign wb_hit_a  = wb_valid & wb_regwrite & (wb_rd == ex_rs1) & (ex_rs1 != '0);
   assign wb_hit_b  = wb_valid & wb_regwrite & (wb_rd == ex_rs2) & (ex_rs2 != '0);

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_valid) begin
         if (mem_hit_a)     fwd_a = 2'b10;
         else if (wb_hit_a) fwd_a = 2'b01;
         if (mem_hit_b)     fwd_b = 2'b10;
         else if (wb_hit_b) fwd_b = 2'b01;
      end
   end

   assign ex_load_hit = id_valid & ex_valid & ex_memread & ex_regwrite & (ex_rd != '0)
                      & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
   assign stall     = ex_load_hit & ~branch_taken;
   assign flush_id  = branch_taken;
   assign ex_bubble = stall | branch_taken;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid     <= 1'b0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         ex_rd        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         mem_valid    <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_memread  <= 1'b0;
         mem_rd       <= '0;
         wb_valid     <= 1'b0;
         wb_regwrite  <= 1'b0;
         wb_memread   <= 1'b0;
         wb_rd        <= '0;
      end else begin
         wb_valid     <= mem_valid;
         wb_regwrite  <= mem_regwrite;
         wb_memread   <= mem_memread;
         wb_rd        <= mem_rd;
         mem_valid    <= ex_valid;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         mem_rd       <= ex_rd;
         if (ex_bubble) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid <= id_valid;
         end
         ex_regwrite <= id_regwrite;
         ex_memread  <= id_memread;
         ex_rd       <= id_rd;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

   localparam int REGW = 5;
   localparam int CNTW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            id_valid;
   logic [REGW-1:0] id_rs1, id_rs2, id_rd;
   logic            id_regwrite, id_memread, branch_taken;
   logic [1:0]      fwd_a, fwd_b;
   logic            stall, flush_id, ex_bubble;
   logic [CNTW-1:0] stall_cnt;

   int nvec = 0;
   int nfail = 0;

   fwd_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .branch_taken(branch_taken), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .stall(stall), .flush_id(flush_id), .ex_bubble(ex_bubble),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr);
      id_valid    = v;
      id_rs1      = REGW'(rs1);
      id_rs2      = REGW'(rs2);
      id_rd       = REGW'(rd);
      id_regwrite = rw;
      id_memread  = mr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      branch_taken = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      branch_taken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), $urandom_range(31), $urandom_range(31), $urandom_range(31),
               1'($urandom), 1'($urandom));
         tick();
         nvec++;
         if ({fwd_a, fwd_b, stall, flush_id, ex_bubble} !== 7'b0 || stall_cnt !== 2'd0) begin
            nfail++;
            $display("FAIL reset: got fa=%b fb=%b st=%b fl=%b bub=%b cnt=%0d want all 0",
                     fwd_a, fwd_b, stall, flush_id, ex_bubble, stall_cnt);
         end
      end
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_alu_chain();
      do_reset();
      drive(1'b1, 1, 2, 5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5, 1, 6, 1'b1, 1'b0);
      tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         nfail++;
         $display("FAIL alu_mem: got fa=%b fb=%b want fa=10 fb=00", fwd_a, fwd_b);
      end
      do_reset();
      drive(1'b1, 1, 2, 5, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1, 2, 9, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5, 1, 6, 1'b1, 1'b0);
      tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
         nfail++;
         $display("FAIL alu_wb: got fa=%b fb=%b want fa=01 fb=00", fwd_a, fwd_b);
      end
   endtask

   task automatic test_priority();
      do_reset();
      drive(1'b1, 1, 2, 7, 1'b1, 1'b0);
      tick();
      tick();
      drive(1'b1, 7, 7, 8, 1'b1, 1'b0);
      tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         nfail++;
         $display("FAIL prio_mem: got fa=%b fb=%b want 10 10", fwd_a, fwd_b);
      end
      do_reset();
      drive(1'b1, 1, 2, 0, 1'b1, 1'b0);
      tick();
      tick();
      drive(1'b1, 0, 0, 8, 1'b1, 1'b0);
      tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         nfail++;
         $display("FAIL prio_x0: got fa=%b fb=%b want 00 00", fwd_a, fwd_b);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 1, 2, 3, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1, 3, 4, 1'b1, 1'b0);
      #1;
      nvec++;
      if (stall !== 1'b1 || ex_bubble !== 1'b1 || stall_cnt !== 2'd0) begin
         nfail++;
         $display("FAIL lu_stall: got st=%b bub=%b cnt=%0d want 1 1 0", stall, ex_bubble, stall_cnt);
      end
      tick();
      nvec++;
      if (stall !== 1'b0 || ex_bubble !== 1'b0 || stall_cnt !== 2'd1) begin
         nfail++;
         $display("FAIL lu_once: got st=%b bub=%b cnt=%0d want 0 0 1", stall, ex_bubble, stall_cnt);
      end
      tick();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (fwd_b !== 2'b01 || fwd_a !== 2'b00 || stall_cnt !== 2'd1) begin
         nfail++;
         $display("FAIL lu_fwd: got fa=%b fb=%b cnt=%0d want 00 01 1", fwd_a, fwd_b, stall_cnt);
      end
   endtask

   task automatic test_branch_vs_stall();
      do_reset();
      drive(1'b1, 1, 2, 3, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1, 3, 4, 1'b1, 1'b0);
      branch_taken = 1'b1;
      #1;
      nvec++;
      if (stall !== 1'b0 || flush_id !== 1'b1 || ex_bubble !== 1'b1) begin
         nfail++;
         $display("FAIL br_ctl: got st=%b fl=%b bub=%b want 0 1 1", stall, flush_id, ex_bubble);
      end
      tick();
      branch_taken = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      nvec++;
      if (stall_cnt !== 2'd0 || flush_id !== 1'b0) begin
         nfail++;
         $display("FAIL br_cnt: got cnt=%0d fl=%b want 0 0", stall_cnt, flush_id);
      end
   endtask

   task automatic test_saturation();
      logic [CNTW-1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      drive(1'b1, 1, 2, 3, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3, 0, 3, 1'b1, 1'b1);
         #1;
         nvec++;
         if (stall !== 1'b1) begin
            nfail++;
            $display("FAIL sat_stall%0d: got st=%b want 1", i, stall);
         end
         tick();
         nvec++;
         if (stall_cnt !== exp_cnt[i]) begin
            nfail++;
            $display("FAIL sat_cnt%0d: got %0d want %0d", i, stall_cnt, exp_cnt[i]);
         end
         tick();
      end
      #1;
      nvec++;
      if (stall !== 1'b1) begin
         nfail++;
         $display("FAIL mid_pre: got st=%b want 1", stall);
      end
      reset_n = 1'b0;
      #1;
      nvec++;
      if (stall !== 1'b0 || stall_cnt !== 2'd0 || ex_bubble !== 1'b0) begin
         nfail++;
         $display("FAIL mid_reset: got st=%b cnt=%0d bub=%b want 0 0 0", stall, stall_cnt, ex_bubble);
      end
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      branch_taken = 1'b0;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #2;
      test_reset();
      test_alu_chain();
      test_priority();
      test_load_use();
      test_branch_vs_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
